// File: rtl/regfile_op_sequencer.sv
// Execute/write-back sequencer for a 4x4-bit register file: one register-to-register
// instruction per 4 cycles, with registered CARRY/ZERO flags.
//
//   state | meaning
//   IDLE  | ready for an instruction; latch fields on INSTR_VALID
//   READ  | drive source addresses, capture Adata/Bdata at the closing edge
//   EXEC  | compute result and flag candidates
//   WRITE | drive the write port; register file and flags update at the closing edge
module regfile_op_sequencer #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  input  logic [2:0]        OPCODE,
  input  logic [ADDR_W-1:0] DST,
  input  logic [ADDR_W-1:0] SRCA,
  input  logic [ADDR_W-1:0] SRCB,
  input  logic [DATA_W-1:0] IMM,
  input  logic [DATA_W-1:0] Adata,
  input  logic [DATA_W-1:0] Bdata,
  output logic [ADDR_W-1:0] Aaddr,
  output logic [ADDR_W-1:0] Baddr,
  output logic [ADDR_W-1:0] Daddr,
  output logic [DATA_W-1:0] Data,
  output logic              Write,
  output logic              DONE,
  output logic              CARRY,
  output logic              ZERO
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_LDI = 3'b101,
    OP_MOV = 3'b110,
    OP_SHL = 3'b111
  } op_t;

  localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  op_t                 op_q;
  logic [ADDR_W-1:0]   dst_q, aaddr_q, baddr_q, daddr_q;
  logic [DATA_W-1:0]   imm_q, a_q, b_q, res_q;
  logic                carry_c_q, zero_c_q, carry_q, zero_q;

  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   alu_r;
  logic                alu_c, alu_z;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    INSTR_READY = 1'b0;
    Write       = 1'b0;
    DONE        = 1'b0;
    Data        = '0;
    case (state_q)
      IDLE: begin
        INSTR_READY = 1'b1;
        if (INSTR_VALID) state_d = READ;
      end
      READ:  state_d = EXEC;
      EXEC:  state_d = WRITE;
      WRITE: begin
        Write   = 1'b1;
        DONE    = 1'b1;
        Data    = res_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Carry defaults to the current flag so LDI/MOV leave it untouched.
  always_comb begin
    sum   = '0;
    alu_r = '0;
    alu_c = carry_q;
    case (op_q)
      OP_ADD: begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        alu_r = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      OP_SUB: begin
        sum   = {1'b0, a_q} + {1'b0, ~b_q} + ONE;
        alu_r = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      OP_AND: begin
        alu_r = a_q & b_q;
        alu_c = 1'b0;
      end
      OP_OR: begin
        alu_r = a_q | b_q;
        alu_c = 1'b0;
      end
      OP_XOR: begin
        alu_r = a_q ^ b_q;
        alu_c = 1'b0;
      end
      OP_LDI: alu_r = imm_q;
      OP_MOV: alu_r = a_q;
      OP_SHL: begin
        alu_r = {a_q[DATA_W-2:0], 1'b0};
        alu_c = a_q[DATA_W-1];
      end
      default: alu_r = '0;
    endcase
    alu_z = (alu_r == '0);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      op_q      <= OP_ADD;
      dst_q     <= '0;
      imm_q     <= '0;
      aaddr_q   <= '0;
      baddr_q   <= '0;
      daddr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_c_q <= 1'b0;
      zero_c_q  <= 1'b0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (INSTR_VALID) begin
            op_q    <= op_t'(OPCODE);
            dst_q   <= DST;
            imm_q   <= IMM;
            aaddr_q <= SRCA;
            baddr_q <= SRCB;
          end
        end
        READ: begin
          a_q <= Adata;
          b_q <= Bdata;
        end
        EXEC: begin
          res_q     <= alu_r;
          carry_c_q <= alu_c;
          zero_c_q  <= alu_z;
          daddr_q   <= dst_q;
        end
        WRITE: begin
          carry_q <= carry_c_q;
          zero_q  <= zero_c_q;
        end
        default: ;
      endcase
    end
  end

  assign Aaddr = aaddr_q;
  assign Baddr = baddr_q;
  assign Daddr = daddr_q;
  assign CARRY = carry_q;
  assign ZERO  = zero_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: behavioural register file + instruction model,
// directed scenarios and randomized traffic checked every cycle.
module tb_regfile_op_sequencer;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       INSTR_VALID = 1'b0;
  logic [2:0] OPCODE = '0;
  logic [1:0] DST = '0, SRCA = '0, SRCB = '0;
  logic [3:0] IMM = '0;
  logic       INSTR_READY, Write, DONE, CARRY, ZERO;
  logic [1:0] Aaddr, Baddr, Daddr;
  logic [3:0] Data, Adata, Bdata;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  regfile_op_sequencer #(.DATA_W(4), .ADDR_W(2)) dut (
    .CLK(CLK), .RESETn(RESETn), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .OPCODE(OPCODE), .DST(DST), .SRCA(SRCA), .SRCB(SRCB), .IMM(IMM),
    .Adata(Adata), .Bdata(Bdata), .Aaddr(Aaddr), .Baddr(Baddr), .Daddr(Daddr),
    .Data(Data), .Write(Write), .DONE(DONE), .CARRY(CARRY), .ZERO(ZERO)
  );

  // Environment register file: combinational read, write on the clock edge, not reset.
  logic [3:0] rf [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  assign Adata = rf[Aaddr];
  assign Bdata = rf[Bdata === 4'bx ? 2'd0 : Baddr];
  always @(posedge CLK) if (Write) rf[Daddr] <= Data;

  // Reference: {carry, zero, result} of one instruction from plain arithmetic.
  function automatic logic [5:0] model_op(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input logic [3:0] imm,
                                          input logic cin);
    int r;
    logic c;
    r = 0;
    c = cin;
    case (op)
      3'd0: begin r = int'(a) + int'(b); c = (r > 15); end
      3'd1: begin r = int'(a) - int'(b); c = (a >= b); end
      3'd2: begin r = int'(a & b); c = 1'b0; end
      3'd3: begin r = int'(a | b); c = 1'b0; end
      3'd4: begin r = int'(a ^ b); c = 1'b0; end
      3'd5: r = int'(imm);
      3'd6: r = int'(a);
      default: begin r = int'(a) * 2; c = (a >= 4'd8); end
    endcase
    r = r & 15;
    return {c, (r == 0), 4'(r)};
  endfunction

  // Model: instruction accepted when idle; write-back lands on the 3rd edge after acceptance.
  logic [3:0] m_rf [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  int         m_busy;
  logic       m_c, m_z, m_rc, m_rz;
  logic [3:0] m_res;
  logic [1:0] m_dst, m_sa, m_sb, m_daddr;

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      m_busy  <= 0;
      m_c     <= 1'b0;
      m_z     <= 1'b0;
      m_res   <= '0;
      m_sa    <= '0;
      m_sb    <= '0;
      m_daddr <= '0;
    end else begin
      case (m_busy)
        0: if (INSTR_VALID) begin
          m_busy <= 1;
          m_sa   <= SRCA;
          m_sb   <= SRCB;
          m_dst  <= DST;
          {m_rc, m_rz, m_res} <= model_op(OPCODE, m_rf[SRCA], m_rf[SRCB], IMM, m_c);
        end
        1: m_busy <= 2;
        2: begin m_busy <= 3; m_daddr <= m_dst; end
        default: begin
          m_busy      <= 0;
          m_rf[m_dst] <= m_res;
          m_c         <= m_rc;
          m_z         <= m_rz;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("ready", 8'(INSTR_READY), 8'(m_busy == 0));
    check("write", 8'(Write), 8'(m_busy == 3));
    check("done",  8'(DONE), 8'(m_busy == 3));
    check("data",  8'(Data), (m_busy == 3) ? 8'(m_res) : 8'd0);
    check("daddr", 8'(Daddr), 8'(m_daddr));
    check("aaddr", 8'(Aaddr), 8'(m_sa));
    check("baddr", 8'(Baddr), 8'(m_sb));
    check("carry", 8'(CARRY), 8'(m_c));
    check("zero",  8'(ZERO), 8'(m_z));
  endtask

  task automatic tick();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] d, input logic [1:0] a,
                       input logic [1:0] b, input logic [3:0] imm);
    OPCODE = op; DST = d; SRCA = a; SRCB = b; IMM = imm;
  endtask

  // Issues one instruction from IDLE and returns what the write port showed.
  task automatic issue(input logic [2:0] op, input logic [1:0] d, input logic [1:0] a,
                       input logic [1:0] b, input logic [3:0] imm,
                       output logic [3:0] wdata, output logic [1:0] waddr, output int lat);
    drive(op, d, a, b, imm);
    INSTR_VALID = 1'b1;
    lat = 0;
    wdata = '0;
    waddr = '0;
    do begin
      tick();
      lat++;
      INSTR_VALID = 1'b0;
    end while (!Write && lat < 12);
    check("write_seen", 8'(Write), 8'd1);
    wdata = Data;
    waddr = Daddr;
    check("done_with_write", 8'(DONE), 8'd1);
    tick();
    check("write_one_cycle", 8'(Write), 8'd0);
  endtask

  logic [3:0] wd;
  logic [1:0] wa;
  int         lat;
  int         cnt;

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 6; i++) begin
      INSTR_VALID = 1'($urandom);
      drive(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom));
      tick();
      check("rst_ready", 8'(INSTR_READY), 8'd1);
      check("rst_write", 8'(Write), 8'd0);
      check("rst_data", 8'(Data), 8'd0);
    end
    INSTR_VALID = 1'b0;
    RESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_no_write", 8'(Write), 8'd0);
    end

    // LDI R2 = 9
    issue(3'b101, 2'd2, 2'd0, 2'd0, 4'd9, wd, wa, lat);
    check("ldi_latency", 8'(lat), 8'd3);
    check("ldi_data", 8'(wd), 8'd9);
    check("ldi_daddr", 8'(wa), 8'd2);
    check("ldi_rf", 8'(rf[2]), 8'd9);
    check("ldi_model", 8'(m_rf[2]), 8'd9);
    check("ldi_zero", 8'(ZERO), 8'd0);

    // ADD overflow: 9 + 9
    issue(3'b101, 2'd1, 2'd0, 2'd0, 4'd9, wd, wa, lat);
    issue(3'b000, 2'd3, 2'd1, 2'd2, 4'd0, wd, wa, lat);
    check("add_data", 8'(wd), 8'd2);
    check("add_carry", 8'(CARRY), 8'd1);
    check("add_zero", 8'(ZERO), 8'd0);

    // SUB borrow, then SUB to zero
    issue(3'b101, 2'd0, 2'd0, 2'd0, 4'd3, wd, wa, lat);
    issue(3'b101, 2'd1, 2'd0, 2'd0, 4'd5, wd, wa, lat);
    issue(3'b001, 2'd3, 2'd0, 2'd1, 4'd0, wd, wa, lat);
    check("sub_data", 8'(wd), 8'hE);
    check("sub_carry", 8'(CARRY), 8'd0);
    issue(3'b001, 2'd3, 2'd0, 2'd0, 4'd0, wd, wa, lat);
    check("sub0_data", 8'(wd), 8'd0);
    check("sub0_carry", 8'(CARRY), 8'd1);
    check("sub0_zero", 8'(ZERO), 8'd1);

    // Back-to-back with INSTR_VALID held: LDI R1=7 then SHL R2=R1
    drive(3'b101, 2'd1, 2'd0, 2'd0, 4'd7);
    INSTR_VALID = 1'b1;
    tick();
    drive(3'b111, 2'd2, 2'd1, 2'd0, 4'd0);
    cnt = 0;
    while (!INSTR_READY && cnt < 10) begin
      cnt++;
      tick();
    end
    check("b2b_ready_low", 8'(cnt), 8'd3);
    tick();
    INSTR_VALID = 1'b0;
    cnt = 0;
    while (!Write && cnt < 10) begin
      cnt++;
      tick();
    end
    check("b2b_write_seen", 8'(Write), 8'd1);
    check("b2b_shl_data", 8'(Data), 8'hE);
    tick();
    check("b2b_carry", 8'(CARRY), 8'd0);
    check("b2b_rf", 8'(rf[2]), 8'hE);

    // Reset during EXEC of an ADD targeting R3
    issue(3'b101, 2'd3, 2'd0, 2'd0, 4'd5, wd, wa, lat);
    drive(3'b000, 2'd3, 2'd1, 2'd2, 4'd0);
    INSTR_VALID = 1'b1;
    tick();
    INSTR_VALID = 1'b0;
    tick();
    #1 RESETn = 1'b0;
    #1;
    check("midrst_ready", 8'(INSTR_READY), 8'd1);
    check("midrst_write", 8'(Write), 8'd0);
    tick();
    RESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst_no_write", 8'(Write), 8'd0);
    end
    check("midrst_rf", 8'(rf[3]), 8'd5);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      INSTR_VALID = ($urandom_range(0, 3) != 0);
      drive(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom));
      RESETn = ($urandom_range(0, 79) != 0);
      tick();
    end
    RESETn = 1'b1;
    INSTR_VALID = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    for (int r = 0; r < 4; r++) check("final_rf", 8'(rf[r]), 8'(m_rf[r]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
Multi-cycle execute/write-back sequencer that consumes the 4-entry x 4-bit register file's read ports and drives its write port. It accepts one register-to-register instruction at a time through a valid/ready handshake, reads two source registers, computes a 4-bit ALU result and writes it back to the destination register. It also maintains CARRY/ZERO flags. One instruction completes every 4 cycles; there is no overlap between instructions, so no hazards exist.

Parameters:
DATA_W, 4, register/operand width; only 4 is supported by the register file.
ADDR_W, 2, register address width; only 2 is supported.

Ports:
CLK  input  1  rising-edge clock, shared with the register file
RESETn  input  1  asynchronous, active-low reset
INSTR_VALID  input  1  instruction fields valid
INSTR_READY  output  1  sequencer can accept an instruction
OPCODE  input  3  operation select, encoding below
DST  input  ADDR_W  destination register
SRCA  input  ADDR_W  source A register
SRCB  input  ADDR_W  source B register
IMM  input  DATA_W  immediate, used by LDI only
Adata  input  DATA_W  register file read port A (combinational read)
Bdata  input  DATA_W  register file read port B (combinational read)
Aaddr  output  ADDR_W  read address A to register file
Baddr  output  ADDR_W  read address B to register file
Daddr  output  ADDR_W  write address to register file
Data  output  DATA_W  write data to register file
Write  output  1  write enable to register file
DONE  output  1  one-cycle pulse, coincident with Write
CARRY  output  1  carry/no-borrow flag
ZERO  output  1  result-zero flag

Behaviour:
- Clock and reset: one clock (CLK). Reset is asynchronous and active-low (RESETn).
- Reset values: state=IDLE; INSTR_READY=1; Write=0; DONE=0; Aaddr=Baddr=Daddr=0; Data=0; CARRY=0; ZERO=0. All internal latches (instruction, operands, result) are cleared.
- FSM states: IDLE, READ, EXEC, WRITE. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - INSTR_READY=1.
  - On a rising edge with INSTR_VALID=1, latch OPCODE/DST/SRCA/SRCB/IMM and go to READ. Otherwise stay in IDLE.
  - INSTR_VALID=0 in IDLE has no effect.
- READ:
  - INSTR_READY=0. Aaddr=latched SRCA, Baddr=latched SRCB.
  - At the next edge, capture Adata/Bdata into operand registers A/B, then go to EXEC.
- EXEC:
  - Compute the result from the opcode table below and register result, CARRY and ZERO candidates. Go to WRITE.
- WRITE:
  - Write=1, DONE=1, Daddr=latched DST, Data=result. The register file commits at the closing edge. Go to IDLE.
- Latency: handshake at edge T; Write is high during cycle T+2..T+3; the register file updates at edge T+3; INSTR_READY returns to 1 after edge T+3.
- Idle drive values: Aaddr/Baddr hold their last values. Outside WRITE, Write=0 and Data=0; Daddr holds its last value.
- Opcode table (C = CARRY, Z = ZERO):
  - 000 ADD: {C,R}=A+B
  - 001 SUB: {C,R}=A+~B+1 (C=1 when A>=B, unsigned)
  - 010 AND: R=A&B, C=0
  - 011 OR: R=A|B, C=0
  - 100 XOR: R=A^B, C=0
  - 101 LDI: R=IMM, C unchanged
  - 110 MOV: R=A, C unchanged
  - 111 SHL: R={A[2:0],0}, C=A[3]
- Flags: ZERO=(R==0) for every opcode. Flags update at the same edge the register file commits, i.e. the end of WRITE, and hold until the next write-back.
- Arithmetic: results are truncated to 4 bits; overflow is visible only via CARRY.
- DST equal to SRCA/SRCB is legal: operands are captured before the write.
- Back-to-back: if INSTR_VALID is held high, the next instruction is accepted on the first IDLE edge. Its READ observes the previous write-back.
- Reset mid-operation: any state returns to IDLE immediately. Write/DONE drop asynchronously. The in-flight instruction is discarded and no partial write occurs.

Test Plan:
- Reset: hold RESETn=0 with random inputs -> INSTR_READY=1, Write=0, Data=0, CARRY=0, ZERO=0; after release, no Write without INSTR_VALID.
- LDI: OPCODE=101, DST=2, IMM=9 -> Write high exactly one cycle, 2 cycles after acceptance, with Daddr=2, Data=9, DONE=1; R2 reads 9; ZERO=0.
- ADD overflow: R1=9, R2=9, ADD DST=3, SRCA=1, SRCB=2 -> Data=2, CARRY=1, ZERO=0.
- SUB borrow/zero: R0=3, R1=5, SUB 0-1 -> Data=E, CARRY=0; then SUB R0-R0 -> Data=0, CARRY=1, ZERO=1.
- Back-to-back dependency: INSTR_VALID held high with LDI R1=7 followed by SHL R2=R1 -> INSTR_READY low 3 cycles between accepts; second write Data=E, CARRY=0.
- Reset during EXEC of ADD -> Write never asserts, target register unchanged, INSTR_READY=1 immediately.
